series_datapath: RTL and testbench

Datapath responder for the five-strobe iterative controller. It holds the operand, a running term and an accumulator, and it computes the fixed-point power sum result = Σ x^k for k = 0 … ITER-1. It executes exactly one register action per load strobe and returns Done so the controller can leave its iteration loop.

---
 rtl/series_datapath.sv | 110 +++++++++++
 tb/tb_series_datapath.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/series_datapath.sv
// Datapath responder for the five-strobe iterative controller: accumulates sum of x^k, k=0..ITER-1.
// Optional DP_SAT_EN: clamp the multiply and accumulate results on overflow instead of wrapping.
module series_datapath #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int ITER  = 8,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ldI,
  input  logic                    ldInit,
  input  logic                    ldM,
  input  logic                    ldRes,
  input  logic                    ldA,
  input  logic signed [WIDTH-1:0] x_in,
  output logic                    Done,
  output logic signed [WIDTH-1:0] result,
  output logic                    err
);

  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]        LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0]        CMAX = CNT_W'(ITER);

  logic signed [WIDTH-1:0] xr_q, xr_d, term_q, term_d, prod_q, prod_d, res_q, res_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    done_q, done_d, init_ok_q, init_ok_d, err_q, err_d;

  logic signed [2*WIDTH-1:0] prod_full, prod_shr;
  logic signed [WIDTH:0]     sum_full;
  logic signed [WIDTH-1:0]   prod_nx, sum_nx;
  logic                      prod_ovf, sum_ovf, multi, op_no_init;
  logic [2:0]                nstb;

  assign prod_full = term_q * xr_q;
  assign prod_shr  = prod_full >>> FRAC;
  // Result fits WIDTH only if every discarded upper bit equals the new sign bit.
  assign prod_ovf  = prod_shr[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_shr[WIDTH-1]}};
  assign sum_full  = {res_q[WIDTH-1], res_q} + {term_q[WIDTH-1], term_q};
  assign sum_ovf   = sum_full[WIDTH] != sum_full[WIDTH-1];

`ifdef DP_SAT_EN
  assign prod_nx = prod_ovf ? (prod_shr[2*WIDTH-1] ? MINV : MAXV) : prod_shr[WIDTH-1:0];
  assign sum_nx  = sum_ovf  ? (sum_full[WIDTH]     ? MINV : MAXV) : sum_full[WIDTH-1:0];
`else
  assign prod_nx = prod_shr[WIDTH-1:0];
  assign sum_nx  = sum_full[WIDTH-1:0];
`endif

  assign nstb       = {2'b0, ldI} + {2'b0, ldInit} + {2'b0, ldM} + {2'b0, ldRes} + {2'b0, ldA};
  assign multi      = nstb > 3'd1;
  assign op_no_init = (ldM | ldRes | ldA) & ~init_ok_q;

  always_comb begin
    xr_d      = ldI ? x_in : xr_q;
    term_d    = term_q;
    prod_d    = prod_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    init_ok_d = init_ok_q;
    if (ldM)   prod_d = prod_nx;
    if (ldRes) res_d  = sum_nx;
    if (ldA) begin
      term_d = prod_q;
      cnt_d  = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
      if (cnt_q == LAST) done_d = 1'b1;
    end
    // ldInit wins over any concurrent operation strobe.
    if (ldInit) begin
      term_d    = ONE;
      prod_d    = '0;
      res_d     = '0;
      cnt_d     = '0;
      done_d    = 1'b0;
      init_ok_d = 1'b1;
    end
    err_d = (ldInit ? 1'b0 : err_q) | multi | op_no_init;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xr_q      <= '0;
      term_q    <= '0;
      prod_q    <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      init_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      xr_q      <= xr_d;
      term_q    <= term_d;
      prod_q    <= prod_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      init_ok_q <= init_ok_d;
      err_q     <= err_d;
    end
  end

  assign Done   = done_q | (init_ok_q & (cnt_q == LAST));
  assign result = res_q;
  assign err    = err_q;

endmodule

// File: tb/tb_series_datapath.sv
// Self-checking bench for series_datapath: vector table, hand sequences, randomized model check.
module tb_series_datapath;
  localparam int WIDTH = 16, FRAC = 8, ITER = 4, CNT_W = 4;
  localparam logic [4:0] S_I = 5'b10000, S_INIT = 5'b01000, S_M = 5'b00100,
                         S_R = 5'b00010, S_A = 5'b00001, S_0 = 5'b00000;

  logic clk = 1'b0, rst = 1'b0;
  logic ldI = 0, ldInit = 0, ldM = 0, ldRes = 0, ldA = 0;
  logic signed [WIDTH-1:0] x_in = '0, result;
  logic Done, err;
  int nchk = 0, nerr = 0;

  series_datapath #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ldI(ldI), .ldInit(ldInit), .ldM(ldM), .ldRes(ldRes), .ldA(ldA),
    .x_in(x_in), .Done(Done), .result(result), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive strobes for one cycle; optionally check Done mid-cycle before the sampling edge.
  task automatic step(input logic [4:0] s, input bit cd, input logic ed, input string nm);
    {ldI, ldInit, ldM, ldRes, ldA} = s;
    @(negedge clk);
    if (cd) check(nm, {15'b0, Done}, {15'b0, ed});
    @(posedge clk); #1;
    {ldI, ldInit, ldM, ldRes, ldA} = S_0;
  endtask

  function automatic logic signed [15:0] clamp(input longint v);
`ifdef DP_SAT_EN
    if (v > 32767) return 16'sh7FFF;
    if (v < -32768) return 16'sh8000;
    return 16'(v);
`else
    return 16'(v);
`endif
  endfunction

  // Reference: sum of x^k using integer fixed-point arithmetic.
  function automatic logic [15:0] model(input logic signed [15:0] x, input int n);
    longint term = 256, res = 0, p;
    for (int k = 0; k < n; k++) begin
      p = (term * longint'(x)) >>> FRAC;
      res = longint'(clamp(res + term));
      term = longint'(clamp(p));
    end
    return 16'(res);
  endfunction

  task automatic run_seq(input logic [15:0] x, input int n, input string nm);
    x_in = x;
    step(S_I, 0, 0, nm);
    x_in = 16'hDEAD;
    step(S_INIT, 0, 0, nm);
    for (int k = 0; k < n; k++) begin
      step(S_M, 0, 0, nm);
      step(S_R, 0, 0, nm);
      step(S_A, 1, (k >= ITER - 1), {nm, "_done_at_ldA"});
    end
  endtask

  typedef struct { logic [15:0] x; int n; logic [15:0] exp_res; logic exp_done; } vec_t;
  vec_t vt[5];

  initial begin
    vt[0] = '{16'h0080, 4, 16'h01E0, 1'b1};
    vt[1] = '{16'h0200, 4, 16'h0F00, 1'b1};
`ifdef DP_SAT_EN
    vt[2] = '{16'h7F00, 2, 16'h7FFF, 1'b0};
`else
    vt[2] = '{16'h7F00, 2, 16'h8000, 1'b0};
`endif
    vt[3] = '{16'hFF00, 4, 16'h0000, 1'b1};
    vt[4] = '{16'h0000, 6, 16'h0100, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 16'h0000);
    check("rst_done", {15'b0, Done}, 16'h0);
    check("rst_err", {15'b0, err}, 16'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    step(S_M, 0, 0, "");
    check("err_op_before_init", {15'b0, err}, 16'h1);
    step(S_INIT, 0, 0, "");
    check("err_cleared_by_init", {15'b0, err}, 16'h0);
    step(S_R | S_A, 0, 0, "");
    check("err_dual_strobe", {15'b0, err}, 16'h1);
    step(S_M, 0, 0, "");
    check("err_sticky", {15'b0, err}, 16'h1);
    step(S_INIT, 0, 0, "");
    check("err_clear2", {15'b0, err}, 16'h0);

    for (int i = 0; i < 5; i++) begin
      run_seq(vt[i].x, vt[i].n, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_result", i), result, vt[i].exp_res);
      check($sformatf("vec%0d_done", i), {15'b0, Done}, {15'b0, vt[i].exp_done});
      check($sformatf("vec%0d_err", i), {15'b0, err}, 16'h0);
      if (i == 1) begin
        step(S_0, 0, 0, "");
        check("done_held", {15'b0, Done}, 16'h1);
        step(S_INIT, 0, 0, "");
        check("init_drops_done", {15'b0, Done}, 16'h0);
        check("init_clears_result", result, 16'h0000);
      end
    end

    // Reset asserted during the second ldRes.
    x_in = 16'h0080;
    step(S_I, 0, 0, "");
    step(S_INIT, 0, 0, "");
    step(S_M, 0, 0, ""); step(S_R, 0, 0, ""); step(S_A, 0, 0, "");
    step(S_M, 0, 0, "");
    ldRes = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_result", result, 16'h0000);
    check("midrst_done", {15'b0, Done}, 16'h0);
    check("midrst_err", {15'b0, err}, 16'h0);
    @(posedge clk); #1;
    ldRes = 1'b0;
    rst = 1'b1;
    run_seq(16'h0080, 4, "postrst");
    check("postrst_result", result, 16'h01E0);

    for (int t = 0; t < 12; t++) begin
      logic [15:0] rx;
      int rn;
      rx = 16'($urandom_range(0, 16'hFFFF));
      if (t % 2 == 0) rx = 16'($signed(rx) >>> 7);
      rn = $urandom_range(1, 6);
      run_seq(rx, rn, $sformatf("rnd%0d", t));
      check($sformatf("rnd%0d_x%h_n%0d", t, rx, rn), result, model(rx, rn));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
